// File: rtl/cache_fill_fsm_if.sv
// Handshake bundle between the cache, main memory and the block-fill miss handler.
interface cache_fill_fsm_if;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        memory_data_valid;
    logic        fsm_busy;
    logic        mem_read_en;
    logic [15:0] mem_req_address;
    logic        write_data_array;
    logic        write_tag_array;
    logic [15:0] fill_address;

    // master: the cache/memory side; slave: the fill FSM
    modport master (
        output miss_detected, miss_address, memory_data_valid,
        input  fsm_busy, mem_read_en, mem_req_address, write_data_array, write_tag_array,
               fill_address
    );

    modport slave (
        input  miss_detected, miss_address, memory_data_valid,
        output fsm_busy, mem_read_en, mem_req_address, write_data_array, write_tag_array,
               fill_address
    );
endinterface

// File: rtl/cache_fill_fsm.sv
// Cache miss handler: streams one word request per cycle for a whole block and writes the
// in-order returning words (and finally the tag) into the cache arrays.
module cache_fill_fsm #(
    parameter int unsigned BLOCK_WORDS = 8
) (
    input  logic             clk,
    input  logic             rst,
    cache_fill_fsm_if.slave  bus
);

    localparam int unsigned OffW = $clog2(BLOCK_WORDS) + 1;
    localparam int unsigned RspW = $clog2(BLOCK_WORDS);

    typedef enum logic {StIdle, StFill} state_e;

    state_e          state_q, state_d;
    logic [15:0]     base_q, base_d;
    logic [OffW-1:0] req_cnt_q, req_cnt_d;
    logic [RspW-1:0] rsp_cnt_q, rsp_cnt_d;

    logic        req_pending;
    logic        last_rsp;
    logic [15:0] req_offset;
    logic [15:0] rsp_offset;

    assign req_pending = req_cnt_q < OffW'(BLOCK_WORDS);
    assign last_rsp    = rsp_cnt_q == RspW'(BLOCK_WORDS - 1);
    // Offsets stay inside the block, so the held count never carries into the base.
    assign req_offset  = 16'(req_cnt_q[OffW-2:0]) << 1;
    assign rsp_offset  = 16'(rsp_cnt_q) << 1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            base_q    <= '0;
            req_cnt_q <= '0;
            rsp_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            req_cnt_q <= req_cnt_d;
            rsp_cnt_q <= rsp_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        req_cnt_d = req_cnt_q;
        rsp_cnt_d = rsp_cnt_q;

        bus.fsm_busy         = 1'b0;
        bus.mem_read_en      = 1'b0;
        bus.mem_req_address  = base_q;
        bus.write_data_array = 1'b0;
        bus.write_tag_array  = 1'b0;
        bus.fill_address     = base_q;

        unique case (state_q)
            StIdle: begin
                if (bus.miss_detected) begin
                    state_d   = StFill;
                    base_d    = {bus.miss_address[15:OffW], {OffW{1'b0}}};
                    req_cnt_d = '0;
                    rsp_cnt_d = '0;
                end
            end
            StFill: begin
                bus.fsm_busy        = 1'b1;
                bus.mem_read_en     = req_pending;
                bus.mem_req_address = base_q + req_offset;
                bus.fill_address    = base_q + rsp_offset;
                if (req_pending) begin
                    req_cnt_d = req_cnt_q + OffW'(1);
                end
                if (bus.memory_data_valid) begin
                    bus.write_data_array = 1'b1;
                    if (last_rsp) begin
                        bus.write_tag_array = 1'b1;
                        rsp_cnt_d           = '0;
                        state_d             = StIdle;
                    end else begin
                        rsp_cnt_d = rsp_cnt_q + RspW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule
